// File: rtl/scs8hd_and3b_sweep_ctl.sv
// Exhaustive 8-vector sweep controller for the and3b cell (X = !AN & B & C).
// Drives AN/B/C, waits a settle time, checks X and records errors.
module scs8hd_and3b_sweep_ctl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1,
  parameter int ERR_W         = 8
) (
  input  logic             CLK,
  input  logic             RESETB,
  input  logic             START,
  input  logic             ABORT,
  input  logic             X_OBS,
  output logic             AN_DRV,
  output logic             B_DRV,
  output logic             C_DRV,
  output logic [2:0]       VEC_IDX,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic             FAIL_VALID,
  output logic [2:0]       FAIL_VEC
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_e;

  localparam int CW = (SETTLE_CYCLES > 0) ?
                      $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES);
  localparam logic [LW-1:0] LOOP_LAST = LW'(LOOPS - 1);
  localparam bit HAS_SETTLE = (SETTLE_CYCLES > 0);

  state_e           state_q, state_d;
  logic [2:0]       vec_q, vec_d;
  logic [LW-1:0]    loop_q, loop_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fval_q, fval_d;
  logic [2:0]       fvec_q, fvec_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;

  logic go;
  logic expect_x;
  logic mismatch;
  logic last_vec;
  logic last_loop;

  assign go        = START & ~ABORT;
  assign expect_x  = ~vec_q[2] & vec_q[1] & vec_q[0];
  assign mismatch  = (X_OBS != expect_x);
  assign last_vec  = (vec_q == 3'd7);
  assign last_loop = (loop_q == LOOP_LAST);

  always_ff @(posedge CLK) begin
    if (!RESETB) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (go) state_d = S_APPLY;
      end
      S_APPLY: begin
        if (ABORT)           state_d = S_IDLE;
        else if (HAS_SETTLE) state_d = S_SETTLE;
        else                 state_d = S_CHECK;
      end
      S_SETTLE: begin
        if (ABORT)             state_d = S_IDLE;
        else if (cnt_q <= CW'(1)) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (ABORT)                       state_d = S_IDLE;
        else if (last_vec && last_loop)  state_d = S_DONE;
        else                             state_d = S_APPLY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vec_d  = vec_q;
    loop_d = loop_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    fval_d = fval_q;
    fvec_d = fvec_q;
    done_d = done_q;
    pass_d = pass_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          vec_d  = '0;
          loop_d = '0;
          err_d  = '0;
          fval_d = 1'b0;
          fvec_d = '0;
          done_d = 1'b0;
          pass_d = 1'b0;
        end
      end
      S_APPLY: begin
        cnt_d = SETTLE_LD;
        if (ABORT) vec_d = '0;
      end
      S_SETTLE: begin
        cnt_d = cnt_q - CW'(1);
        if (ABORT) vec_d = '0;
      end
      S_CHECK: begin
        if (ABORT) begin
          vec_d = '0;
        end else begin
          if (mismatch) begin
            if (err_q != '1) err_d = err_q + ERR_W'(1);
            if (!fval_q) begin
              fval_d = 1'b1;
              fvec_d = vec_q;
            end
          end
          vec_d = vec_q + 3'd1;
          if (last_vec) begin
            if (last_loop) begin
              done_d = 1'b1;
              pass_d = (err_d == '0);
            end else begin
              loop_d = loop_q + LW'(1);
            end
          end
        end
      end
      default: vec_d = '0;
    endcase
    busy_d = (state_d == S_APPLY) ||
             (state_d == S_SETTLE) ||
             (state_d == S_CHECK);
  end

  always_ff @(posedge CLK) begin
    if (!RESETB) begin
      vec_q  <= '0;
      loop_q <= '0;
      cnt_q  <= '0;
      err_q  <= '0;
      fval_q <= 1'b0;
      fvec_q <= '0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      vec_q  <= vec_d;
      loop_q <= loop_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      fval_q <= fval_d;
      fvec_q <= fvec_d;
      done_q <= done_d;
      pass_q <= pass_d;
      busy_q <= busy_d;
    end
  end

  assign AN_DRV     = vec_q[2];
  assign B_DRV      = vec_q[1];
  assign C_DRV      = vec_q[0];
  assign VEC_IDX    = vec_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign PASS       = pass_q;
  assign ERR_CNT    = err_q;
  assign FAIL_VALID = fval_q;
  assign FAIL_VEC   = fvec_q;

endmodule

// File: tb/tb_scs8hd_and3b_sweep_ctl.sv
// Bench for the and3b sweep controller: two configurations checked each
// cycle against a position-based sweep model.
module tb_scs8hd_and3b_sweep_ctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, abort, xa, xb;

  logic       a_an, a_b, a_c, a_busy, a_done, a_pass, a_fv;
  logic [2:0] a_vi, a_fvec;
  logic [7:0] a_err;
  logic       b_an, b_b, b_c, b_busy, b_done, b_pass, b_fv;
  logic [2:0] b_vi, b_fvec;
  logic [1:0] b_err;

  scs8hd_and3b_sweep_ctl #(
    .SETTLE_CYCLES(2), .LOOPS(1), .ERR_W(8)
  ) u_a (
    .CLK(clk), .RESETB(rst_n), .START(start), .ABORT(abort),
    .X_OBS(xa), .AN_DRV(a_an), .B_DRV(a_b), .C_DRV(a_c),
    .VEC_IDX(a_vi), .BUSY(a_busy), .DONE(a_done), .PASS(a_pass),
    .ERR_CNT(a_err), .FAIL_VALID(a_fv), .FAIL_VEC(a_fvec)
  );

  scs8hd_and3b_sweep_ctl #(
    .SETTLE_CYCLES(0), .LOOPS(2), .ERR_W(2)
  ) u_b (
    .CLK(clk), .RESETB(rst_n), .START(start), .ABORT(abort),
    .X_OBS(xb), .AN_DRV(b_an), .B_DRV(b_b), .C_DRV(b_c),
    .VEC_IDX(b_vi), .BUSY(b_busy), .DONE(b_done), .PASS(b_pass),
    .ERR_CNT(b_err), .FAIL_VALID(b_fv), .FAIL_VEC(b_fvec)
  );

  int n_chk = 0;
  int n_err = 0;
  int mode  = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  // Model: a sweep is a position counter; vector and check slot follow
  // from division by the per-vector period.
  int per[2]   = '{4, 2};
  int nloop[2] = '{1, 2};
  int emax[2]  = '{255, 3};
  bit m_act[2], m_done[2], m_pass[2], m_fv[2];
  int m_pos[2], m_err[2], m_fvec[2];

  function automatic int mvec(int k);
    return m_act[k] ? (m_pos[k] / per[k]) % 8 : 0;
  endfunction

  task automatic model_step(int k, bit r, bit s, bit ab, bit x);
    int v;
    bit ex;
    if (!r) begin
      m_act[k] = 0; m_pos[k] = 0; m_done[k] = 0; m_pass[k] = 0;
      m_err[k] = 0; m_fv[k] = 0; m_fvec[k] = 0;
    end else if (m_act[k]) begin
      if (ab) begin
        m_act[k] = 0;
        m_pos[k] = 0;
      end else begin
        v = mvec(k);
        if (m_pos[k] % per[k] == per[k] - 1) begin
          ex = (v == 3);
          if (x != ex) begin
            if (m_err[k] < emax[k]) m_err[k]++;
            if (!m_fv[k]) begin
              m_fv[k] = 1;
              m_fvec[k] = v;
            end
          end
        end
        m_pos[k]++;
        if (m_pos[k] == nloop[k] * 8 * per[k]) begin
          m_act[k] = 0;
          m_pos[k] = 0;
          m_done[k] = 1;
          m_pass[k] = (m_err[k] == 0);
        end
      end
    end else if (s && !ab) begin
      m_act[k] = 1; m_pos[k] = 0; m_done[k] = 0; m_pass[k] = 0;
      m_err[k] = 0; m_fv[k] = 0; m_fvec[k] = 0;
    end
  endtask

  task automatic cmp(int k, logic [2:0] drv, logic [2:0] vi, logic bz,
                     logic dn, logic ps, logic [7:0] er, logic fv,
                     logic [2:0] fvec);
    string p;
    p = (k == 0) ? "a" : "b";
    check({p, "_drv"},   drv,  mvec(k));
    check({p, "_vec"},   vi,   mvec(k));
    check({p, "_busy"},  bz,   m_act[k]);
    check({p, "_done"},  dn,   m_done[k]);
    check({p, "_pass"},  ps,   m_pass[k]);
    check({p, "_err"},   er,   m_err[k]);
    check({p, "_fv"},    fv,   m_fv[k]);
    check({p, "_fvec"},  fvec, m_fvec[k]);
  endtask

  function automatic logic xval(logic an, logic b, logic c);
    case (mode)
      0:       return ~an & b & c;
      1:       return 1'b0;
      2:       return 1'b1;
      default: return 1'($urandom % 2);
    endcase
  endfunction

  task automatic cyc();
    bit r, s, ab, x0, x1;
    r = rst_n; s = start; ab = abort; x0 = xa; x1 = xb;
    @(posedge clk);
    model_step(0, r, s, ab, x0);
    model_step(1, r, s, ab, x1);
    #1;
    cmp(0, {a_an, a_b, a_c}, a_vi, a_busy, a_done, a_pass,
        8'(a_err), a_fv, a_fvec);
    cmp(1, {b_an, b_b, b_c}, b_vi, b_busy, b_done, b_pass,
        8'(b_err), b_fv, b_fvec);
    xa = xval(a_an, a_b, a_c);
    xb = xval(b_an, b_b, b_c);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_pos(int p, string tag);
    int n;
    n = 0;
    while (!(m_act[0] && m_pos[0] == p) && n < 200) begin
      cyc();
      n++;
    end
    check({tag, "_reached"}, 32'(n < 200), 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    xa = 1'b0; xb = 1'b0;
    repeat (2) cyc();
    check("rst_busy", a_busy, 0);
    check("rst_err", a_err, 0);
    rst_n = 1'b1;
    cyc();

    mode = 0;
    pulse_start();
    repeat (35) cyc();
    check("ideal_a_pass", a_pass, 1);
    check("ideal_a_done", a_done, 1);
    check("ideal_b_pass", b_pass, 1);

    mode = 1;
    pulse_start();
    repeat (35) cyc();
    check("s0_a_err", a_err, 1);
    check("s0_a_fvec", a_fvec, 3);
    check("s0_a_pass", a_pass, 0);
    check("s0_b_err", b_err, 2);

    mode = 2;
    pulse_start();
    repeat (35) cyc();
    check("s1_a_err", a_err, 7);
    check("s1_a_fvec", a_fvec, 0);
    check("s1_b_err", b_err, 3);
    check("s1_b_pass", b_pass, 0);

    mode = 1;
    pulse_start();
    wait_pos(15, "abort");
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("abort_busy", a_busy, 0);
    check("abort_drv", {a_an, a_b, a_c}, 0);
    check("abort_done", a_done, 0);
    check("abort_err", a_err, 0);
    mode = 0;
    pulse_start();
    repeat (35) cyc();
    check("after_abort_pass", a_pass, 1);

    mode = 2;
    pulse_start();
    wait_pos(21, "rst_mid");
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check("midrst_err", a_err, 0);
    check("midrst_fv", a_fv, 0);
    start = 1'b1;
    abort = 1'b1;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", a_busy, 0);
    repeat (3) cyc();

    mode = 0;
    start = 1'b1;
    repeat (75) cyc();
    start = 1'b0;
    repeat (40) cyc();

    repeat (3000) begin
      rst_n = ($urandom % 300) != 0;
      start = ($urandom % 8) == 0;
      abort = ($urandom % 40) == 0;
      if ($urandom % 60 == 0) mode = $urandom % 4;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
